// File: rtl/cmp_arbiter_pkg.sv
// Shared definitions for the comparator arbiter: op encodings, widths and
// the request bundle routed through the grant mux.
package cmp_arbiter_pkg;

   localparam int DATA_W = 32;
   localparam int OP_W   = 3;

   localparam logic [OP_W-1:0] CMPOP_EQ = 3'd0;
   localparam logic [OP_W-1:0] CMPOP_NE = 3'd1;
   localparam logic [OP_W-1:0] CMPOP_LT = 3'd2;
   localparam logic [OP_W-1:0] CMPOP_LE = 3'd3;
   localparam logic [OP_W-1:0] CMPOP_GT = 3'd4;
   localparam logic [OP_W-1:0] CMPOP_GE = 3'd5;

   typedef struct packed {
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
      logic [OP_W-1:0]   op;
   } cmp_req_t;

endpackage

// File: rtl/cmp_arbiter_cmp.sv
// Combinational 32-bit comparator. Equality is bitwise; ordering ops treat
// operands as two's complement. Unknown op codes yield 0.
module cmp_arbiter_cmp
   import cmp_arbiter_pkg::*;
(
   input  logic [DATA_W-1:0] i_op1,
   input  logic [DATA_W-1:0] i_op2,
   input  logic [OP_W-1:0]   i_op,
   output logic              o_result
);

   // Evaluate the selected comparison
   always_comb begin
      o_result = 1'b0;
      case (i_op)
         CMPOP_EQ: o_result = (i_op1 == i_op2);
         CMPOP_NE: o_result = (i_op1 != i_op2);
         CMPOP_LT: o_result = ($signed(i_op1) <  $signed(i_op2));
         CMPOP_LE: o_result = ($signed(i_op1) <= $signed(i_op2));
         CMPOP_GT: o_result = ($signed(i_op1) >  $signed(i_op2));
         CMPOP_GE: o_result = ($signed(i_op1) >= $signed(i_op2));
         default:  o_result = 1'b0;
      endcase
   end

endmodule

// File: rtl/cmp_arbiter.sv
// Shares one comparator between the branch resolver (port 0) and the trap
// evaluator (port 1) with round-robin arbitration and one-entry result buffers.
module cmp_arbiter
   import cmp_arbiter_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_op1,
   input  logic [DATA_W-1:0] req0_op2,
   input  logic [OP_W-1:0]   req0_op,
   output logic              resp0_valid,
   input  logic              resp0_ready,
   output logic              resp0_result,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_op1,
   input  logic [DATA_W-1:0] req1_op2,
   input  logic [OP_W-1:0]   req1_op,
   output logic              resp1_valid,
   input  logic              resp1_ready,
   output logic              resp1_result,
   output logic [CNT_W-1:0]  conflict_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             r_last_grant;
   logic             r_resp0_valid;
   logic             r_resp0_result;
   logic             r_resp1_valid;
   logic             r_resp1_result;
   logic [CNT_W-1:0] r_conflict_cnt;

   logic             w_elig0;
   logic             w_elig1;
   logic [1:0]       w_grant;
   cmp_req_t         w_req0;
   cmp_req_t         w_req1;
   cmp_req_t         w_sel;
   logic             w_cmp_result;
   logic [1:0]       w_deny;
   logic [CNT_W:0]   w_cnt_sum;
   logic [CNT_W-1:0] w_cnt_next;

   // A buffer may be refilled in the same cycle its current result is drained
   assign w_elig0 = req0_valid & (~r_resp0_valid | resp0_ready);
   assign w_elig1 = req1_valid & (~r_resp1_valid | resp1_ready);

   // Round-robin grant; ties go to the port that did not win last
   always_comb begin
      w_grant = 2'b00;
      case ({w_elig1, w_elig0})
         2'b01:   w_grant = 2'b01;
         2'b10:   w_grant = 2'b10;
         2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
         default: w_grant = 2'b00;
      endcase
      if (!reset_n) begin
         w_grant = 2'b00;
      end else begin
         w_grant = w_grant;
      end
   end

   assign req0_ready = w_grant[0];
   assign req1_ready = w_grant[1];

   assign w_req0 = '{op1: req0_op1, op2: req0_op2, op: req0_op};
   assign w_req1 = '{op1: req1_op1, op2: req1_op2, op: req1_op};

   // Route the granted port's operands to the shared comparator
   always_comb begin
      if (w_grant[1]) begin
         w_sel = w_req1;
      end else begin
         w_sel = w_req0;
      end
   end

   cmp_arbiter_cmp u_cmp (
      .i_op1    (w_sel.op1),
      .i_op2    (w_sel.op2),
      .i_op     (w_sel.op),
      .o_result (w_cmp_result)
   );

   // Port 0 response buffer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_resp0_valid  <= 1'b0;
         r_resp0_result <= 1'b0;
      end else if (w_grant[0]) begin
         r_resp0_valid  <= 1'b1;
         r_resp0_result <= w_cmp_result;
      end else if (resp0_ready) begin
         r_resp0_valid  <= 1'b0;
      end
   end

   // Port 1 response buffer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_resp1_valid  <= 1'b0;
         r_resp1_result <= 1'b0;
      end else if (w_grant[1]) begin
         r_resp1_valid  <= 1'b1;
         r_resp1_result <= w_cmp_result;
      end else if (resp1_ready) begin
         r_resp1_valid  <= 1'b0;
      end
   end

   // Priority only moves on an actual acceptance
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last_grant <= 1'b1;
      end else if (w_grant[0]) begin
         r_last_grant <= 1'b0;
      end else if (w_grant[1]) begin
         r_last_grant <= 1'b1;
      end
   end

   // Denied requests this cycle, 0..2, added with saturation
   always_comb begin
      w_deny    = {1'b0, req0_valid & ~w_grant[0]} + {1'b0, req1_valid & ~w_grant[1]};
      w_cnt_sum = {1'b0, r_conflict_cnt} + {{(CNT_W-1){1'b0}}, w_deny};
      if (w_cnt_sum > {1'b0, CNT_MAX}) begin
         w_cnt_next = CNT_MAX;
      end else begin
         w_cnt_next = w_cnt_sum[CNT_W-1:0];
      end
   end

   // Conflict counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_conflict_cnt <= {CNT_W{1'b0}};
      end else begin
         r_conflict_cnt <= w_cnt_next;
      end
   end

   assign resp0_valid  = r_resp0_valid;
   assign resp0_result = r_resp0_result;
   assign resp1_valid  = r_resp1_valid;
   assign resp1_result = r_resp1_result;
   assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: a driver predicts grants, buffer occupancy
// and counters from the arbitration rules; a monitor checks consumed results.
module tb_cmp_arbiter;

   logic        clk;
   logic        reset_n;
   logic        req0_valid, req1_valid, resp0_ready, resp1_ready;
   logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
   logic [2:0]  req0_op, req1_op;
   logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
   logic        resp0_result, resp1_result;
   logic [15:0] conflict_cnt;
   logic        s_req0_ready, s_req1_ready, s_resp0_valid, s_resp1_valid;
   logic        s_resp0_result, s_resp1_result;
   logic [1:0]  s_conflict_cnt;

   int n_cmp = 0;
   int n_fail = 0;

   logic exp0_q[$];
   logic exp1_q[$];

   // model state
   bit occ0, occ1, acc0, acc1, cons0, cons1, lg;
   int cnt, cnt_s, deny;

   cmp_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
      .req0_op2(req0_op2), .req0_op(req0_op), .resp0_valid(resp0_valid),
      .resp0_ready(resp0_ready), .resp0_result(resp0_result),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
      .req1_op2(req1_op2), .req1_op(req1_op), .resp1_valid(resp1_valid),
      .resp1_ready(resp1_ready), .resp1_result(resp1_result),
      .conflict_cnt(conflict_cnt)
   );

   cmp_arbiter #(.CNT_W(2)) dut_sat (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_op1(req0_op1),
      .req0_op2(req0_op2), .req0_op(req0_op), .resp0_valid(s_resp0_valid),
      .resp0_ready(resp0_ready), .resp0_result(s_resp0_result),
      .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_op1(req1_op1),
      .req1_op2(req1_op2), .req1_op(req1_op), .resp1_valid(s_resp1_valid),
      .resp1_ready(resp1_ready), .resp1_result(s_resp1_result),
      .conflict_cnt(s_conflict_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Comparison computed from the difference of sign-extended operands
   function automatic logic ref_cmp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      longint d;
      d = longint'($signed(a)) - longint'($signed(b));
      case (op)
         3'd0:    return d == 0;
         3'd1:    return d != 0;
         3'd2:    return d < 0;
         3'd3:    return d <= 0;
         3'd4:    return d > 0;
         3'd5:    return d >= 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0005;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   function automatic int sat_add(input int v, input int d, input int mx);
      return (v + d > mx) ? mx : v + d;
   endfunction

   // One clock cycle: advance the model over the edge, apply inputs, predict, check
   task automatic step(input bit v0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [2:0] o0, input bit rr0,
                       input bit v1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic [2:0] o1, input bit rr1);
      bit e0, e1, g0, g1;
      @(posedge clk);
      #1;
      if (acc0) occ0 = 1; else if (cons0) occ0 = 0;
      if (acc1) occ1 = 1; else if (cons1) occ1 = 0;
      if (acc0) lg = 0; else if (acc1) lg = 1;
      cnt   = sat_add(cnt, deny, 65535);
      cnt_s = sat_add(cnt_s, deny, 3);

      req0_valid = v0; req0_op1 = a0; req0_op2 = b0; req0_op = o0; resp0_ready = rr0;
      req1_valid = v1; req1_op1 = a1; req1_op2 = b1; req1_op = o1; resp1_ready = rr1;

      e0 = v0 && (!occ0 || rr0);
      e1 = v1 && (!occ1 || rr1);
      g0 = e0 && (!e1 || lg);
      g1 = e1 && (!e0 || !lg);
      acc0 = g0; acc1 = g1;
      cons0 = occ0 && rr0; cons1 = occ1 && rr1;
      deny = int'(v0 && !g0) + int'(v1 && !g1);
      if (g0) exp0_q.push_back(ref_cmp(a0, b0, o0));
      if (g1) exp1_q.push_back(ref_cmp(a1, b1, o1));

      @(negedge clk);
      chk("req0_ready", req0_ready, g0);
      chk("req1_ready", req1_ready, g1);
      chk("resp0_valid", resp0_valid, occ0);
      chk("resp1_valid", resp1_valid, occ1);
      chk("conflict_cnt", conflict_cnt, cnt);
      chk("conflict_cnt_sat", s_conflict_cnt, cnt_s);
   endtask

   task automatic model_reset();
      occ0 = 0; occ1 = 0; acc0 = 0; acc1 = 0; cons0 = 0; cons1 = 0;
      lg = 1; cnt = 0; cnt_s = 0; deny = 0;
      exp0_q.delete();
      exp1_q.delete();
   endtask

   task automatic idle_inputs();
      req0_valid = 0; req0_op1 = '0; req0_op2 = '0; req0_op = 3'd0; resp0_ready = 0;
      req1_valid = 0; req1_op1 = '0; req1_op2 = '0; req1_op = 3'd0; resp1_ready = 0;
   endtask

   // Monitor: pop and compare whenever a buffered result is consumed
   always @(negedge clk) begin
      logic e;
      if (reset_n) begin
         if (resp0_valid && resp0_ready) begin
            if (exp0_q.size() == 0) chk("resp0_unexpected", 64'd1, 64'd0);
            else begin
               e = exp0_q.pop_front();
               chk("resp0_result", resp0_result, e);
            end
         end
         if (resp1_valid && resp1_ready) begin
            if (exp1_q.size() == 0) chk("resp1_unexpected", 64'd1, 64'd0);
            else begin
               e = exp1_q.pop_front();
               chk("resp1_result", resp1_result, e);
            end
         end
      end
   end

   initial begin
      idle_inputs();
      model_reset();
      reset_n = 0;
      req0_valid = 1;
      repeat (2) @(posedge clk);
      #2;
      chk("reset_req0_ready", req0_ready, 1'b0);
      chk("reset_resp0_valid", resp0_valid, 1'b0);
      chk("reset_resp0_result", resp0_result, 1'b0);
      chk("reset_resp1_result", resp1_result, 1'b0);
      chk("reset_conflict_cnt", conflict_cnt, 16'd0);
      idle_inputs();
      #1 reset_n = 1;

      // single port: LT then GT on -1 vs 0
      step(1, 32'hFFFF_FFFF, 32'h0, 3'd2, 1, 0, 32'h0, 32'h0, 3'd0, 1);
      step(1, 32'hFFFF_FFFF, 32'h0, 3'd4, 1, 0, 32'h0, 32'h0, 3'd0, 1);
      step(0, 32'h0, 32'h0, 3'd0, 1, 0, 32'h0, 32'h0, 3'd0, 1);
      // tie round-robin
      repeat (4) step(1, 32'd5, 32'd5, 3'd0, 1, 1, 32'd5, 32'd5, 3'd1, 1);
      // backpressure on port 1
      step(0, 32'd0, 32'd0, 3'd0, 1, 1, 32'd3, 32'd7, 3'd2, 0);
      repeat (3) step(1, 32'd9, 32'd2, 3'd5, 1, 1, 32'd7, 32'd3, 3'd2, 0);
      step(1, 32'd9, 32'd2, 3'd5, 1, 1, 32'd7, 32'd3, 3'd2, 1);
      step(0, 32'd0, 32'd0, 3'd0, 1, 0, 32'd0, 32'd0, 3'd0, 1);
      // undefined op
      step(1, 32'd4, 32'd4, 3'd7, 1, 0, 32'd0, 32'd0, 3'd0, 1);
      step(1, 32'd4, 32'd4, 3'd6, 1, 0, 32'd0, 32'd0, 3'd0, 1);

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         step($urandom_range(0, 3) != 0, pick_operand(), pick_operand(), 3'($urandom_range(0, 7)),
              $urandom_range(0, 2) != 0,
              $urandom_range(0, 3) != 0, pick_operand(), pick_operand(), 3'($urandom_range(0, 7)),
              $urandom_range(0, 2) != 0);
      end

      // reset with a result pending on port 0
      step(1, 32'd1, 32'd2, 3'd2, 0, 1, 32'd1, 32'd1, 3'd0, 1);
      step(0, 32'd0, 32'd0, 3'd0, 0, 1, 32'd1, 32'd1, 3'd0, 1);
      step(0, 32'd0, 32'd0, 3'd0, 0, 0, 32'd0, 32'd0, 3'd0, 1);
      chk("pre_reset_resp0_valid", resp0_valid, 1'b1);
      #2 reset_n = 0;
      #1;
      chk("async_reset_resp0_valid", resp0_valid, 1'b0);
      chk("async_reset_conflict_cnt", conflict_cnt, 16'd0);
      chk("async_reset_cnt_sat", s_conflict_cnt, 2'd0);
      idle_inputs();
      model_reset();
      @(posedge clk);
      #1 reset_n = 1;

      // first tie after reset must go to port 0
      step(1, 32'd8, 32'd3, 3'd4, 1, 1, 32'd8, 32'd3, 3'd3, 1);
      step(1, 32'd8, 32'd3, 3'd4, 1, 1, 32'd8, 32'd3, 3'd3, 1);
      repeat (3) step(0, 32'd0, 32'd0, 3'd0, 1, 0, 32'd0, 32'd0, 3'd0, 1);
      #1;
      chk("drain_q0_empty", 64'(exp0_q.size()), 64'd0);
      chk("drain_q1_empty", 64'(exp1_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
